// File: rtl/seq_table_counter.sv
// Modulo-DEPTH up/down index mapped to a registered output word through binary,
// Gray or a run-time programmable lookup table.
module seq_table_counter #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q,
  output logic [AW-1:0]    idx,
  output logic             wrap
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0]    idx_reg, idx_next;
  logic             wrap_reg, wrap_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [AW-1:0]    gray_next;
  logic [WIDTH-1:0] table_rd [DEPTH];

  // Each entry resets to its own address; addresses >= DEPTH match no entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        entry_reg <= WIDTH'(gi);
      end else if (wr_en && (wr_addr == AW'(gi))) begin
        entry_reg <= wr_data;
      end
    end

    assign table_rd[gi] = entry_reg;
  end

  always_comb begin
    idx_next  = idx_reg;
    wrap_next = 1'b0;
    if (clr) begin
      idx_next = '0;
    end else if (en) begin
      if (!dir) begin
        if (idx_reg == LAST) begin
          idx_next  = '0;
          wrap_next = 1'b1;
        end else begin
          idx_next = idx_reg + AW'(1);
        end
      end else begin
        if (idx_reg == '0) begin
          idx_next  = LAST;
          wrap_next = 1'b1;
        end else begin
          idx_next = idx_reg - AW'(1);
        end
      end
    end
  end

  assign gray_next = idx_next ^ (idx_next >> 1);

  // The output follows the index it will sit beside, so q and idx always agree.
  always_comb begin
    q_next = WIDTH'(idx_next);
    case (mode)
      2'b01:   q_next = WIDTH'(gray_next);
      2'b10: begin
        if (wr_en && (wr_addr == idx_next)) begin
          q_next = wr_data;
        end else begin
          q_next = table_rd[idx_next];
        end
      end
      default: q_next = WIDTH'(idx_next);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg  <= '0;
      q_reg    <= '0;
      wrap_reg <= 1'b0;
    end else begin
      idx_reg  <= idx_next;
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
    end
  end

  assign q    = q_reg;
  assign idx  = idx_reg;
  assign wrap = wrap_reg;

endmodule

// File: doc/seq_table_counter.md
# seq_table_counter

Parametrised, clock-enabled sequence generator: an internal index steps up or down modulo DEPTH and is mapped to the registered output through one of three modes: plain binary, Gray code, or a run-time programmable lookup table. It replaces fixed hard-coded-sequence counter FSMs. Any arbitrary output order, such as a scrambled 3-bit sequence, is obtained by loading the table instead of writing a new FSM.

## Interface
- WIDTH, 3, output word width; legal 1..8
- DEPTH, 8, sequence length (index modulus); legal 2..2^WIDTH
- AW, clog2(DEPTH), derived localparam: index/address width; never overridden
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  advance index one step this cycle
- dir  in  1  0 = count up, 1 = count down
- clr  in  1  synchronous clear of index to 0
- mode  in  2  00 binary, 01 Gray, 10 table, 11 reserved (behaves as 00)
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table entry to write
- wr_data  in  WIDTH  table write data
- q  out  WIDTH  registered sequence output
- idx  out  AW  registered current index
- wrap  out  1  registered one-cycle pulse, index wrapped this step

## Operation
- State: idx register, q register, wrap register, table of DEPTH x WIDTH registers.
- Reset (rst low, asynchronous): idx=0, q=0, wrap=0, table[i]=i truncated to WIDTH for all i. Outputs hold these values while rst is low.
- Next index, in priority order:
  - clr=1: idx_n=0 and wrap_n=0, regardless of en.
  - en=1, dir=0: idx_n = idx+1. If idx=DEPTH-1 then idx_n=0 and wrap_n=1.
  - en=1, dir=1: idx_n = idx-1. If idx=0 then idx_n=DEPTH-1 and wrap_n=1.
  - otherwise idx_n=idx and wrap_n=0.
- Output mapping, computed from idx_n and current mode every cycle, enabled or not:
  - binary: q_n = idx_n zero-extended to WIDTH.
  - Gray: q_n = (idx_n ^ (idx_n>>1)) zero-extended. Gray is single-bit-change only when DEPTH is a power of two. At non-power-of-two wrap, the value is still the formula result.
  - table: q_n = table[idx_n]. Write bypass: if wr_en=1 and wr_addr=idx_n, then q_n = wr_data.
- Table write: wr_en=1 stores wr_data at wr_addr on the edge, in any mode. wr_addr >= DEPTH is ignored; no entry changes.
- mode and dir changes take effect on the next edge. idx is never disturbed by a mode change.
- mode=11 is mapped as binary; no error flag.

## Timing
- Single-cycle latency. Inputs sampled at edge N; idx, q and wrap valid after edge N. q always corresponds to the idx presented in the same cycle.
- wrap is high for exactly one cycle per wrapping step. With continuous en and dir=0, wrap pulses every DEPTH cycles, coincident with idx=0.
- Direction reversal at a boundary: a step always uses the dir sampled that cycle. Example: at idx=0 with dir=1, the step goes to DEPTH-1 and wrap=1.
- clr together with en: clr wins, idx=0, wrap=0.
- clr together with wr_en: both happen. In table mode, the bypass applies if wr_addr=0.
- en=0: idx and wrap=0 hold, but q still re-maps. A mode change or table write to idx is visible on q one edge later.
- Reset mid-sequence: outputs go to 0 immediately (asynchronous). The table returns to identity. The first step after release starts from idx=0.
- No combinational path from any input to any output.

## Test plan
- Reset/binary up, defaults: rst low 3 cycles, release, en=1, dir=0, mode=00 for 10 cycles. Required: q=0,1..7,0,1; wrap=1 only when idx returns to 0.
- Down and Gray: mode=01, dir=1, en=1 from idx=0. Required: idx 7,6,5...; q 4,5,7,6,2,3,1,0; wrap on the first step.
- Table program: write entries 0..7 = 0,3,4,2,5,7,6,1 with en=0, then mode=10, en=1. Required: q cycles 0,3,4,2,5,7,6,1,0; idx 0..7.
- Write bypass and out-of-range: DEPTH=6, WIDTH=3, mode=10, idx=2, en=1. Write wr_addr=3 with 7. Required: next q=7. A write with wr_addr=6 changes nothing.
- clr priority and en gating: en=1 and clr=1 at idx=5. Required: idx=0, q=0, wrap=0. en=0 for 4 cycles: idx constant.
- Asynchronous reset mid-run: assert rst between edges at idx=4 after table writes. Required: q=0 and idx=0 immediately; table reads identity after release.
